sfp_ctrl: RTL and testbench

Sequencer for one core's `sfp_row` softmax-normalization datapath in the two-core design. It runs one batch of `rows` psum rows:
- **Accumulate pass:** read rows from psum memory and drive `acc` so that row magnitude-sums are written into the sum FIFOs.
- **Peer sync:** handshake with the peer core's controller.
- **Divide pass:** re-read the rows and drive `div` and `fifo_ext_rd` in lockstep with the peer, then flag the normalized outputs.

---
 rtl/sfp_ctrl_if.sv | 30 +++
 rtl/sfp_ctrl.sv | 126 ++++++++++++
 tb/tb_sfp_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sfp_ctrl_if.sv
// Handshake and bus signals between the sfp_ctrl sequencer and its environment.
// The slave modport is the controller's view; master is the driver's view.
interface sfp_ctrl_if #(
    parameter int CNT_BW = 4
);
    logic              start;
    logic              peer_ready;
    logic              local_ready;
    logic              psum_rd;
    logic [CNT_BW-1:0] psum_addr;
    logic              acc;
    logic              div;
    logic              fifo_ext_rd;
    logic              out_valid;
    logic [CNT_BW-1:0] out_addr;
    logic              busy;
    logic              done;

    modport slave (
        input  start, peer_ready,
        output local_ready, psum_rd, psum_addr, acc, div, fifo_ext_rd,
               out_valid, out_addr, busy, done
    );

    modport master (
        output start, peer_ready,
        input  local_ready, psum_rd, psum_addr, acc, div, fifo_ext_rd,
               out_valid, out_addr, busy, done
    );
endinterface

// File: rtl/sfp_ctrl.sv
// Batch sequencer for one core's sfp_row softmax normalization: accumulate pass,
// lockstep sync with the peer controller, divide pass, drain, done pulse.
module sfp_ctrl #(
    parameter int ROWS   = 8,
    parameter int CNT_BW = 4
) (
    input logic          clk,
    input logic          reset,
    sfp_ctrl_if.slave    bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ACC, S_SYNC, S_DIV, S_DRAIN, S_DONE
    } state_e;

    localparam logic [CNT_BW-1:0] LAST_ROW = CNT_BW'(ROWS - 1);

    state_e            state_q;
    logic [CNT_BW-1:0] psum_addr_q;
    logic [CNT_BW-1:0] row_d1_q;
    logic [CNT_BW-1:0] out_addr_q;
    logic [1:0]        aux_q;
    logic              psum_rd_q;
    logic              acc_q;
    logic              div_q;
    logic              fifo_ext_rd_q;
    logic              out_valid_q;
    logic              local_ready_q;
    logic              busy_q;
    logic              done_q;

    // NOTE: every register here uses <= so all reads in this block see the
    // pre-edge value; blocking = would silently shorten the pipeline delays.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            psum_addr_q   <= '0;
            row_d1_q      <= '0;
            out_addr_q    <= '0;
            aux_q         <= '0;
            psum_rd_q     <= 1'b0;
            acc_q         <= 1'b0;
            div_q         <= 1'b0;
            fifo_ext_rd_q <= 1'b0;
            out_valid_q   <= 1'b0;
            local_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Row data arrives one cycle after the read; the divider adds one more.
            acc_q         <= (state_q == S_ACC);
            div_q         <= (state_q == S_DIV);
            fifo_ext_rd_q <= (state_q == S_DIV);
            out_valid_q   <= div_q;
            row_d1_q      <= psum_addr_q;
            out_addr_q    <= row_d1_q;
            done_q        <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q     <= S_ACC;
                        psum_rd_q   <= 1'b1;
                        psum_addr_q <= '0;
                        busy_q      <= 1'b1;
                    end
                end
                S_ACC: begin
                    if (psum_addr_q == LAST_ROW) begin
                        state_q     <= S_SYNC;
                        psum_rd_q   <= 1'b0;
                        psum_addr_q <= '0;
                        aux_q       <= '0;
                    end else begin
                        psum_addr_q <= psum_addr_q + 1'b1;
                    end
                end
                S_SYNC: begin
                    // Both controllers evaluate the same AND, so they enter DIV together.
                    if (local_ready_q && bus.peer_ready) begin
                        state_q       <= S_DIV;
                        local_ready_q <= 1'b0;
                        psum_rd_q     <= 1'b1;
                    end else if (aux_q == 2'd1) begin
                        local_ready_q <= 1'b1;
                    end else begin
                        aux_q <= aux_q + 2'd1;
                    end
                end
                S_DIV: begin
                    if (psum_addr_q == LAST_ROW) begin
                        state_q     <= S_DRAIN;
                        psum_rd_q   <= 1'b0;
                        psum_addr_q <= '0;
                        aux_q       <= '0;
                    end else begin
                        psum_addr_q <= psum_addr_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (aux_q == 2'd1) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        aux_q <= aux_q + 2'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.local_ready = local_ready_q;
    assign bus.psum_rd     = psum_rd_q;
    assign bus.psum_addr   = psum_addr_q;
    assign bus.acc         = acc_q;
    assign bus.div         = div_q;
    assign bus.fifo_ext_rd = fifo_ext_rd_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_addr    = out_addr_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
endmodule

// File: tb/tb_sfp_ctrl.sv
// Directed bench for sfp_ctrl: per-cycle traces are captured and compared
// against hand-computed cycle masks for rows = 8, 1 and 16.
module tb_sfp_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic peer_tie = 1'b1;
    logic peer_force = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sfp_ctrl_if #(.CNT_BW(4)) bus8 ();
    sfp_ctrl_if #(.CNT_BW(4)) bus1 ();
    sfp_ctrl_if #(.CNT_BW(4)) bus16 ();

    assign bus8.start       = start;
    assign bus1.start       = start;
    assign bus16.start      = start;
    assign bus8.peer_ready  = peer_tie ? bus8.local_ready : peer_force;
    assign bus1.peer_ready  = bus1.local_ready;
    assign bus16.peer_ready = bus16.local_ready;

    sfp_ctrl #(.ROWS(8),  .CNT_BW(4)) u_dut   (.clk(clk), .reset(reset), .bus(bus8));
    sfp_ctrl #(.ROWS(1),  .CNT_BW(4)) u_dut1  (.clk(clk), .reset(reset), .bus(bus1));
    sfp_ctrl #(.ROWS(16), .CNT_BW(4)) u_dut16 (.clk(clk), .reset(reset), .bus(bus16));

    logic [63:0] r_acc, r_div, r_fer, r_ov, r_rd, r_lr, r_done, r_busy;
    logic [63:0] r1_acc, r1_div, r1_ov, r1_done;
    logic [63:0] r16_acc, r16_div, r16_fer, r16_ov, r16_done;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] m(input int lo, input int hi);
        logic [63:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Called #1 after a rising edge; that cycle is cycle 0 and carries start.
    // peer_rise < 0 ties peer_ready to the DUT's own local_ready.
    task automatic capture(input int ncyc, input int peer_rise, input int x1, input int x2);
        int oa_exp = 0;
        {r_acc, r_div, r_fer, r_ov, r_rd, r_lr, r_done, r_busy} = '0;
        {r1_acc, r1_div, r1_ov, r1_done} = '0;
        {r16_acc, r16_div, r16_fer, r16_ov, r16_done} = '0;
        for (int c = 0; c < ncyc; c++) begin
            start      = (c == 0) || (c == x1) || (c == x2);
            peer_tie   = (peer_rise < 0);
            peer_force = (peer_rise >= 0) && (c >= peer_rise);
            @(negedge clk);
            r_acc[c]  = bus8.acc;        r_div[c]  = bus8.div;
            r_fer[c]  = bus8.fifo_ext_rd; r_ov[c]  = bus8.out_valid;
            r_rd[c]   = bus8.psum_rd;    r_lr[c]   = bus8.local_ready;
            r_done[c] = bus8.done;       r_busy[c] = bus8.busy;
            r1_acc[c] = bus1.acc;        r1_div[c] = bus1.div;
            r1_ov[c]  = bus1.out_valid;  r1_done[c] = bus1.done;
            r16_acc[c] = bus16.acc;      r16_div[c] = bus16.div;
            r16_fer[c] = bus16.fifo_ext_rd; r16_ov[c] = bus16.out_valid;
            r16_done[c] = bus16.done;
            if (bus8.out_valid) begin
                check("out_addr", 64'(bus8.out_addr), 64'(oa_exp % 8));
                oa_exp++;
            end
            @(posedge clk);
            #1;
        end
        start    = 1'b0;
        peer_tie = 1'b1;
    endtask

    task automatic check_nominal8(input string pfx);
        check({pfx, "_acc"},  r_acc,  m(2, 9));
        check({pfx, "_rd"},   r_rd,   m(1, 8) | m(12, 19));
        check({pfx, "_lr"},   r_lr,   m(11, 11));
        check({pfx, "_div"},  r_div,  m(13, 20));
        check({pfx, "_fer"},  r_fer,  m(13, 20));
        check({pfx, "_ov"},   r_ov,   m(14, 21));
        check({pfx, "_done"}, r_done, m(22, 22));
        check({pfx, "_busy"}, r_busy, m(1, 22));
    endtask

    initial begin
        logic [63:0] idle_busy;

        // Reset held with start high: nothing may move.
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", 64'({bus8.acc, bus8.div, bus8.fifo_ext_rd, bus8.out_valid,
                                  bus8.psum_rd, bus8.psum_addr, bus8.out_addr,
                                  bus8.local_ready, bus8.done}), 64'd0);
        check("rst_busy", 64'(bus8.busy), 64'd0);
        start = 1'b0;
        reset = 1'b1;
        idle_busy = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle_busy[i] = bus8.busy | bus8.psum_rd;
        end
        check("idle_after_rst", idle_busy, 64'd0);
        @(posedge clk);
        #1;

        // Nominal batch, with the rows=1 and rows=16 instances started alongside.
        capture(42, -1, -1, -1);
        check_nominal8("nom");
        check("nom_no_overlap", r_acc & r_div, 64'd0);
        check("r1_acc",   r1_acc,  m(2, 2));
        check("r1_div",   r1_div,  m(6, 6));
        check("r1_ov",    r1_ov,   m(7, 7));
        check("r1_done",  r1_done, m(8, 8));
        check("r16_acc_n", 64'($countones(r16_acc)), 64'd16);
        check("r16_div",  r16_div, m(21, 36));
        check("r16_fer",  r16_fer, m(21, 36));
        check("r16_ov_n", 64'($countones(r16_ov)), 64'd16);
        check("r16_done", r16_done, m(38, 38));

        // Late peer: peer_ready rises in cycle 16.
        capture(32, 16, -1, -1);
        check("late_lr",   r_lr,   m(11, 16));
        check("late_rd",   r_rd,   m(1, 8) | m(17, 24));
        check("late_div",  r_div,  m(18, 25));
        check("late_done", r_done, m(27, 27));

        // Start pulses while busy are dropped.
        capture(30, -1, 5, 14);
        check("busy_acc_n", 64'($countones(r_acc)), 64'd8);
        check("busy_div_n", 64'($countones(r_div)), 64'd8);
        check("busy_done",  r_done, m(22, 22));

        // Reset asserted mid-DIV clears outputs without an edge.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        check("mid_pre", 64'({bus8.div, bus8.psum_rd, bus8.out_valid, bus8.busy}), 64'hf);
        reset = 1'b0;
        #1;
        check("mid_rst", 64'({bus8.div, bus8.psum_rd, bus8.out_valid, bus8.busy,
                              bus8.acc, bus8.fifo_ext_rd, bus8.done, bus8.local_ready}), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        capture(26, -1, -1, -1);
        check_nominal8("post_rst");

        // Start in DONE is ignored; start in the first IDLE cycle launches batch two.
        capture(50, -1, 22, 23);
        check("b2b_acc",  r_acc,  m(2, 9) | m(25, 32));
        check("b2b_div",  r_div,  m(13, 20) | m(36, 43));
        check("b2b_ov",   r_ov,   m(14, 21) | m(37, 44));
        check("b2b_done", r_done, m(22, 22) | m(45, 45));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule
